// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the controller state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Digit counter width; never below one bit, even for N=1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fa_digit.sv
// DIGIT-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the top bit for overflow detection.
module fa_digit #(
    parameter int D = 4
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         ci,
    output logic [D-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [D:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < D; i++) begin : g_fa
        logic p;
        logic g1;
        logic g2;
        // first half adder: operand bits
        assign p  = a[i] ^ b[i];
        assign g1 = a[i] & b[i];
        // second half adder: partial sum with incoming carry
        assign s[i]   = p ^ c[i];
        assign g2     = p & c[i];
        assign c[i+1] = g1 | g2;
    end

    assign co    = c[D];
    assign c_msb = c[D-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH bits processed DIGIT per clock.
// Operands and results move over registered valid/ready handshakes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(N);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad
        $fatal(1, "serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sumr;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] ds;
    logic             dco;
    logic             dmsb;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(N - 1));

    fa_digit #(
        .D(DIGIT)
    ) u_dig (
        .a    (opa[DIGIT-1:0]),
        .b    (opb[DIGIT-1:0]),
        .ci   (carry),
        .s    (ds),
        .co   (dco),
        .c_msb(dmsb)
    );

    // New digit enters at the MSB end so the result lands aligned after N shifts.
    if (N == 1) begin : g_one
        assign sum_sh = ds;
    end else begin : g_many
        assign sum_sh = {ds, sumr[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            sumr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            // subtraction: invert B and seed the carry with the inverted borrow
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            sumr  <= sum_sh;
            carry <= dco;
            cnt   <= cnt + CW'(1);
            if (last) begin
                cout_r <= dco;
                ovf_r  <= dco ^ dmsb;
            end
        end
    end

    assign sum  = sumr;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at N=4, N=1 and N=16 sharing one stimulus.
// Arithmetic/timing model plus literal checks of each directed vector.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [15:0] sum [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
        .out_ready(out_ready), .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
        .out_ready(out_ready), .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
    );

    serial_adder #(.WIDTH(16), .DIGIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]),
        .out_ready(out_ready), .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2])
    );

    function automatic int nof(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    endfunction

    // {cout, ovf, sum} from plain integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [16:0] f;
        logic [15:0] r;
        logic        co;
        logic        ov;
        if (!s) begin
            f  = {1'b0, x} + {1'b0, y} + {16'd0, c};
            co = f[16];
        end else begin
            f  = {1'b0, x} - {1'b0, y} - {16'd0, c};
            co = ~f[16];
        end
        r  = f[15:0];
        ov = s ? ((x[15] != y[15]) && (r[15] != x[15]))
               : ((x[15] == y[15]) && (r[15] != x[15]));
        return {co, ov, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = waiting for operands, 1 = busy, 2 = result offered
    int          phase [3] = '{0, 0, 0};
    int          rem   [3] = '{0, 0, 0};
    logic [17:0] expv  [3];
    logic        fresh [3] = '{1'b1, 1'b1, 1'b1};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                phase[k] <= 0;
                rem[k]   <= 0;
                fresh[k] <= 1'b1;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (phase[k] == 0) begin
                    if (in_valid) begin
                        expv[k]  <= model(a, b, cin, sub);
                        rem[k]   <= nof(k);
                        phase[k] <= 1;
                        fresh[k] <= 1'b0;
                    end
                end else if (phase[k] == 1) begin
                    rem[k] <= rem[k] - 1;
                    if (rem[k] == 1) phase[k] <= 2;
                end else if (out_ready) begin
                    phase[k] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(phase[k] == 0));
            chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(phase[k] == 2));
            if (phase[k] == 2)
                chk($sformatf("result[%0d]", k), 32'({cout[k], ovf[k], sum[k]}), 32'(expv[k]));
            else if (fresh[k])
                chk($sformatf("reset_out[%0d]", k), 32'({cout[k], ovf[k], sum[k]}), 32'd0);
        end
    end

    task automatic op(input string name, input logic [15:0] x, input logic [15:0] y,
                      input logic c, input logic s, input logic [15:0] es,
                      input logic eco, input logic eov);
        int          lat [3];
        logic [17:0] got [3];
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0;
            got[k] = '0;
        end
        @(negedge clk);
        a = x; b = y; cin = c; sub = s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && lat[k] == 0) begin
                    lat[k] = n;
                    got[k] = {cout[k], ovf[k], sum[k]};
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_lat[%0d]", name, k), 32'(lat[k]), 32'(nof(k)));
            chk($sformatf("%s_val[%0d]", name, k), 32'(got[k]), 32'({eco, eov, es}));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'h7);
        chk("rst_sum", 32'(sum[0]), 32'h0000);
        chk("rst_cout_ovf", 32'({cout[0], ovf[0]}), 32'd0);

        op("add_co",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("sub_brw",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op("sub_bin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        // backpressure: result held while new operands wait on in_valid
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 a = 16'h0F0F; b = 16'h0101;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid", 32'(out_valid[0]), 32'd1);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", 32'({cout[0], ovf[0], sum[0]}), 32'h03333);
            chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", 32'({in_ready[0], out_valid[0]}), 32'b10);
        @(posedge clk);
        #1;
        chk("bp_accept", 32'(in_ready[0]), 32'd0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_next", 32'({out_valid[0], cout[0], ovf[0], sum[0]}), 32'h41010);
        repeat (25) @(posedge clk);

        // reset in the middle of an operation
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'h7);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out0", 32'({cout[0], ovf[0], sum[0]}), 32'd0);
        chk("mid_rst_out2", 32'({cout[2], ovf[2], sum[2]}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
